// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Two-requester arbiter for the data port of the shared dual-port BRAM.
//   The core (c_*) and a debug/loader master (d_*) compete for one access per
//   cycle. Ties are broken round-robin. Debug may lock the port for atomic
//   multi-beat sequences. One-cycle read data is tagged back to its requester.
//
// Ports
//   clk, rst_ni                 clock, asynchronous active-low reset
//   c_req_i/c_we_i/c_addr_i/c_wdata_i/c_size_i/c_sign_i   core request
//   c_ready_o                   core request accepted this cycle
//   c_rvalid_o/c_rdata_o        core read response
//   d_* (same set as core)      debug request and response
//   d_lock_i                    debug keeps exclusive ownership after a grant
//   mem_addr_o/mem_din_o/mem_write_o/mem_read_o/mem_size_o/mem_sign_o
//                               BRAM port controls
//   mem_dout_i                  BRAM read data, one cycle after mem_read_o
module dmem_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_ni,
    input  logic              c_req_i,
    input  logic              c_we_i,
    input  logic [ADDR_W-1:0] c_addr_i,
    input  logic [DATA_W-1:0] c_wdata_i,
    input  logic [1:0]        c_size_i,
    input  logic              c_sign_i,
    output logic              c_ready_o,
    output logic              c_rvalid_o,
    output logic [DATA_W-1:0] c_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    input  logic [1:0]        d_size_i,
    input  logic              d_sign_i,
    input  logic              d_lock_i,
    output logic              d_ready_o,
    output logic              d_rvalid_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_din_o,
    output logic              mem_write_o,
    output logic              mem_read_o,
    output logic [1:0]        mem_size_o,
    output logic              mem_sign_o,
    input  logic [DATA_W-1:0] mem_dout_i
);

    typedef enum logic {ST_ARB, ST_LOCKED} state_e;
    typedef enum logic {OWN_CORE, OWN_DBG} owner_e;

    state_e state_q, state_d;
    owner_e last_q, last_d;
    owner_e rd_owner_q, rd_owner_d;
    logic   rd_pend_q, rd_pend_d;
    logic   grant_c, grant_d;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_ARB;
            last_q     <= OWN_DBG;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= OWN_CORE;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    // Grants are gated by rst_ni so every output is quiet while in reset,
    // even though the request inputs are passed straight through.
    always_comb begin
        grant_c = 1'b0;
        grant_d = 1'b0;
        state_d = state_q;
        last_d  = last_q;
        if (rst_ni) begin
            case (state_q)
                ST_ARB: begin
                    if (c_req_i && d_req_i) begin
                        grant_c = (last_q == OWN_DBG);
                        grant_d = !grant_c;
                    end else begin
                        grant_c = c_req_i;
                        grant_d = d_req_i;
                    end
                    if (grant_d && d_lock_i) state_d = ST_LOCKED;
                end
                ST_LOCKED: begin
                    grant_d = d_req_i;
                    // The exit cycle counts as a debug grant even when idle,
                    // so the core wins the first tie after unlocking.
                    if (!d_lock_i) begin
                        state_d = ST_ARB;
                        last_d  = OWN_DBG;
                    end
                end
                default: state_d = ST_ARB;
            endcase
            if (grant_c)      last_d = OWN_CORE;
            else if (grant_d) last_d = OWN_DBG;
        end
    end

    always_comb begin
        mem_addr_o  = '0;
        mem_din_o   = '0;
        mem_write_o = 1'b0;
        mem_read_o  = 1'b0;
        mem_size_o  = '0;
        mem_sign_o  = 1'b0;
        if (grant_c) begin
            mem_addr_o  = c_addr_i;
            mem_din_o   = c_wdata_i;
            mem_write_o = c_we_i;
            mem_read_o  = !c_we_i;
            mem_size_o  = c_size_i;
            mem_sign_o  = c_sign_i;
        end else if (grant_d) begin
            mem_addr_o  = d_addr_i;
            mem_din_o   = d_wdata_i;
            mem_write_o = d_we_i;
            mem_read_o  = !d_we_i;
            mem_size_o  = d_size_i;
            mem_sign_o  = d_sign_i;
        end
    end

    always_comb begin
        rd_pend_d  = mem_read_o;
        rd_owner_d = rd_owner_q;
        if (mem_read_o) rd_owner_d = grant_d ? OWN_DBG : OWN_CORE;
    end

    assign c_ready_o  = grant_c;
    assign d_ready_o  = grant_d;
    assign c_rvalid_o = rd_pend_q && (rd_owner_q == OWN_CORE);
    assign d_rvalid_o = rd_pend_q && (rd_owner_q == OWN_DBG);
    assign c_rdata_o  = rst_ni ? mem_dout_i : '0;
    assign d_rdata_o  = rst_ni ? mem_dout_i : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        c_req_i, c_we_i, c_sign_i;
    logic [31:0] c_addr_i, c_wdata_i;
    logic [1:0]  c_size_i;
    logic        c_ready_o, c_rvalid_o;
    logic [31:0] c_rdata_o;
    logic        d_req_i, d_we_i, d_sign_i, d_lock_i;
    logic [31:0] d_addr_i, d_wdata_i;
    logic [1:0]  d_size_i;
    logic        d_ready_o, d_rvalid_o;
    logic [31:0] d_rdata_o;
    logic [31:0] mem_addr_o, mem_din_o;
    logic        mem_write_o, mem_read_o, mem_sign_o;
    logic [1:0]  mem_size_o;
    logic [31:0] mem_dout_i = '0;

    int n_tests = 0;
    int n_fail  = 0;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_ni(rst_ni),
        .c_req_i(c_req_i), .c_we_i(c_we_i), .c_addr_i(c_addr_i), .c_wdata_i(c_wdata_i),
        .c_size_i(c_size_i), .c_sign_i(c_sign_i), .c_ready_o(c_ready_o),
        .c_rvalid_o(c_rvalid_o), .c_rdata_o(c_rdata_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
        .d_size_i(d_size_i), .d_sign_i(d_sign_i), .d_lock_i(d_lock_i), .d_ready_o(d_ready_o),
        .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
        .mem_addr_o(mem_addr_o), .mem_din_o(mem_din_o), .mem_write_o(mem_write_o),
        .mem_read_o(mem_read_o), .mem_size_o(mem_size_o), .mem_sign_o(mem_sign_o),
        .mem_dout_i(mem_dout_i)
    );

    always #5 clk = ~clk;

    // Behavioural BRAM: 1024 words, one-cycle read latency, cleared on first edge.
    logic [31:0] bram [0:1023];
    logic        bram_init = 1'b0;
    always @(posedge clk) begin
        if (!bram_init) begin
            for (int i = 0; i < 1024; i++) bram[i] <= '0;
            bram_init <= 1'b1;
        end else begin
            if (mem_write_o) bram[mem_addr_o[11:2]] <= mem_din_o;
            if (mem_read_o)  mem_dout_i <= bram[mem_addr_o[11:2]];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic setc(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd);
        c_req_i = req; c_we_i = we; c_addr_i = addr; c_wdata_i = wd;
    endtask

    task automatic setd(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic lock);
        d_req_i = req; d_we_i = we; d_addr_i = addr; d_wdata_i = wd; d_lock_i = lock;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        setc(0, 0, 0, 0);
        setd(0, 0, 0, 0, 0);
        rst_ni = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;
    endtask

    typedef struct {
        logic c_req, c_we, d_req, d_we, d_lock;
        logic e_crdy, e_drdy, e_crv, e_drv;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(input logic cr, cw, dr, dw, dl, ecr, edr, ecv, edv);
        vec_t v;
        v.c_req = cr; v.c_we = cw; v.d_req = dr; v.d_we = dw; v.d_lock = dl;
        v.e_crdy = ecr; v.e_drdy = edr; v.e_crv = ecv; v.e_drv = edv;
        return v;
    endfunction

    // Random-phase reference model state
    logic        m_locked, m_last_dbg, p_v, p_dbg;
    logic [31:0] p_data;
    logic [31:0] ref_mem [0:15];

    initial begin
        c_size_i = 2'd2; c_sign_i = 1'b0; d_size_i = 2'd2; d_sign_i = 1'b0;

        // Outputs quiet during reset even with requests asserted.
        rst_ni = 1'b0;
        setc(1, 0, 32'h40, 0);
        setd(1, 1, 32'h44, 32'h55, 1);
        #3;
        chkb("rst_c_ready", c_ready_o, 0);
        chkb("rst_d_ready", d_ready_o, 0);
        chkb("rst_mem_read", mem_read_o, 0);
        chkb("rst_mem_write", mem_write_o, 0);
        chk("rst_mem_addr", mem_addr_o, 0);
        chkb("rst_c_rvalid", c_rvalid_o, 0);

        // Table: contention, alternation, dormant lock, lock entry/exit.
        vecs[0]  = mk(0,0,0,0,0, 0,0,0,0);
        vecs[1]  = mk(1,0,1,0,0, 1,0,0,0);
        vecs[2]  = mk(1,0,1,0,0, 0,1,1,0);
        vecs[3]  = mk(1,0,1,0,0, 1,0,0,1);
        vecs[4]  = mk(1,0,1,0,0, 0,1,1,0);
        vecs[5]  = mk(1,1,0,0,0, 1,0,0,1);
        vecs[6]  = mk(1,1,1,1,0, 0,1,0,0);
        vecs[7]  = mk(1,0,0,0,1, 1,0,0,0);
        vecs[8]  = mk(1,0,1,0,1, 0,1,1,0);
        vecs[9]  = mk(1,0,1,0,1, 0,1,0,1);
        vecs[10] = mk(1,0,0,0,1, 0,0,0,1);
        vecs[11] = mk(1,0,1,0,0, 0,1,0,0);
        vecs[12] = mk(1,0,1,0,0, 1,0,0,1);
        vecs[13] = mk(0,0,0,0,0, 0,0,1,0);
        vecs[14] = mk(0,0,0,0,0, 0,0,0,0);
        do_reset;
        for (int i = 0; i < 15; i++) begin
            setc(vecs[i].c_req, vecs[i].c_we, 32'h300 + 32'(i) * 8, 32'h1000 + 32'(i));
            setd(vecs[i].d_req, vecs[i].d_we, 32'h304 + 32'(i) * 8, 32'h2000 + 32'(i), vecs[i].d_lock);
            @(negedge clk);
            chkb($sformatf("vec%0d_c_ready", i), c_ready_o, vecs[i].e_crdy);
            chkb($sformatf("vec%0d_d_ready", i), d_ready_o, vecs[i].e_drdy);
            chkb($sformatf("vec%0d_c_rvalid", i), c_rvalid_o, vecs[i].e_crv);
            chkb($sformatf("vec%0d_d_rvalid", i), d_rvalid_o, vecs[i].e_drv);
            chkb($sformatf("vec%0d_mem_read", i), mem_read_o,
                 (vecs[i].e_crdy & ~vecs[i].c_we) | (vecs[i].e_drdy & ~vecs[i].d_we));
            chkb($sformatf("vec%0d_mem_write", i), mem_write_o,
                 (vecs[i].e_crdy & vecs[i].c_we) | (vecs[i].e_drdy & vecs[i].d_we));
            next_cycle;
        end

        // Core-only write then read.
        do_reset;
        setc(1, 1, 32'h100, 32'hDEADBEEF);
        @(negedge clk);
        chkb("core_wr_ready", c_ready_o, 1);
        chk("core_wr_din", mem_din_o, 32'hDEADBEEF);
        next_cycle;
        setc(1, 0, 32'h100, 0);
        @(negedge clk);
        chkb("core_rd_ready", c_ready_o, 1);
        next_cycle;
        setc(0, 0, 0, 0);
        @(negedge clk);
        chkb("core_rd_rvalid", c_rvalid_o, 1);
        chk("core_rd_rdata", c_rdata_o, 32'hDEADBEEF);
        chkb("core_rd_no_d_rvalid", d_rvalid_o, 0);
        next_cycle;

        // Lock held 4 cycles against a requesting core.
        do_reset;
        setd(1, 0, 32'h100, 0, 1);
        @(negedge clk);
        chkb("lock_entry_d_ready", d_ready_o, 1);
        next_cycle;
        setc(1, 0, 32'h104, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chkb($sformatf("lock%0d_c_ready", i), c_ready_o, 0);
            chkb($sformatf("lock%0d_d_ready", i), d_ready_o, 1);
            next_cycle;
        end
        d_lock_i = 1'b0;
        @(negedge clk);
        chkb("unlock_c_ready", c_ready_o, 0);
        chkb("unlock_d_ready", d_ready_o, 1);
        next_cycle;
        @(negedge clk);
        chkb("after_unlock_c_ready", c_ready_o, 1);
        chkb("after_unlock_d_ready", d_ready_o, 0);
        next_cycle;

        // Back-to-back reads, tagged per requester.
        do_reset;
        setd(1, 1, 32'h200, 32'h11, 0);
        next_cycle;
        setd(1, 1, 32'h204, 32'h22, 0);
        next_cycle;
        setd(0, 0, 0, 0, 0);
        setc(1, 0, 32'h200, 0);
        @(negedge clk);
        chkb("b2b_c_ready", c_ready_o, 1);
        next_cycle;
        setc(0, 0, 0, 0);
        setd(1, 0, 32'h204, 0, 0);
        @(negedge clk);
        chkb("b2b_d_ready", d_ready_o, 1);
        chkb("b2b_c_rvalid", c_rvalid_o, 1);
        chk("b2b_c_rdata", c_rdata_o, 32'h11);
        chkb("b2b_no_d_rvalid", d_rvalid_o, 0);
        next_cycle;
        setd(0, 0, 0, 0, 0);
        @(negedge clk);
        chkb("b2b_d_rvalid", d_rvalid_o, 1);
        chk("b2b_d_rdata", d_rdata_o, 32'h22);
        chkb("b2b_no_c_rvalid", c_rvalid_o, 0);
        next_cycle;

        // Reset asserted while a granted read is outstanding.
        do_reset;
        setc(1, 0, 32'h100, 0);
        @(negedge clk);
        chkb("rmr_c_ready", c_ready_o, 1);
        rst_ni = 1'b0;
        #1;
        chkb("rmr_async_c_ready", c_ready_o, 0);
        chkb("rmr_async_mem_read", mem_read_o, 0);
        next_cycle;
        @(negedge clk);
        chkb("rmr_c_rvalid", c_rvalid_o, 0);
        chkb("rmr_mem_read", mem_read_o, 0);
        chkb("rmr_mem_write", mem_write_o, 0);
        chk("rmr_mem_addr", mem_addr_o, 0);
        rst_ni = 1'b1;
        setd(1, 0, 32'h104, 0, 0);
        #1;
        chkb("rmr_tie_c_ready", c_ready_o, 1);
        chkb("rmr_tie_d_ready", d_ready_o, 0);
        next_cycle;
        @(negedge clk);
        chkb("rmr_post_c_rvalid", c_rvalid_o, 1);
        chkb("rmr_post_d_ready", d_ready_o, 1);
        next_cycle;

        // Randomized traffic against a transaction-level model.
        do_reset;
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        m_locked = 0; m_last_dbg = 1; p_v = 0; p_dbg = 0; p_data = '0;
        setc(0, 0, 0, 0);
        setd(0, 0, 0, 0, 0);
        for (int cyc = 0; cyc < 1500; cyc++) begin
            int win;            // 0 none, 1 core, 2 debug
            logic        w_we;
            logic [31:0] w_addr, w_data;
            logic [1:0]  w_size;
            if (!c_req_i) begin
                setc($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                     {26'd0, 4'($urandom_range(0, 15)), 2'b00}, $urandom);
                c_size_i = 2'($urandom_range(0, 2));
            end
            if (!d_req_i) begin
                setd($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                     {26'd0, 4'($urandom_range(0, 15)), 2'b00}, $urandom, d_lock_i);
                d_size_i = 2'($urandom_range(0, 2));
            end
            d_lock_i = m_locked ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);

            if (m_locked)              win = d_req_i ? 2 : 0;
            else if (c_req_i && d_req_i) win = m_last_dbg ? 1 : 2;
            else if (c_req_i)          win = 1;
            else if (d_req_i)          win = 2;
            else                       win = 0;
            w_we   = (win == 1) ? c_we_i    : d_we_i;
            w_addr = (win == 1) ? c_addr_i  : d_addr_i;
            w_data = (win == 1) ? c_wdata_i : d_wdata_i;
            w_size = (win == 1) ? c_size_i  : d_size_i;

            @(negedge clk);
            chkb("rnd_c_ready", c_ready_o, win == 1);
            chkb("rnd_d_ready", d_ready_o, win == 2);
            chkb("rnd_c_rvalid", c_rvalid_o, p_v && !p_dbg);
            chkb("rnd_d_rvalid", d_rvalid_o, p_v && p_dbg);
            if (p_v) chk("rnd_rdata", p_dbg ? d_rdata_o : c_rdata_o, p_data);
            chkb("rnd_mem_write", mem_write_o, (win != 0) && w_we);
            chkb("rnd_mem_read", mem_read_o, (win != 0) && !w_we);
            chk("rnd_mem_addr", mem_addr_o, (win != 0) ? w_addr : 32'd0);
            chk("rnd_mem_size", {30'd0, mem_size_o}, (win != 0) ? {30'd0, w_size} : 32'd0);
            if (win != 0 && w_we) chk("rnd_mem_din", mem_din_o, w_data);

            p_v   = (win != 0) && !w_we;
            p_dbg = (win == 2);
            if (p_v) p_data = ref_mem[w_addr[5:2]];
            if (win != 0 && w_we) ref_mem[w_addr[5:2]] = w_data;
            if (win == 1) m_last_dbg = 0;
            if (win == 2) m_last_dbg = 1;
            if (m_locked) begin
                if (!d_lock_i) begin m_locked = 0; m_last_dbg = 1; end
            end else if (win == 2 && d_lock_i) begin
                m_locked = 1;
            end
            next_cycle;
            if (win == 1) c_req_i = 1'b0;
            if (win == 2) d_req_i = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
